// File: rtl/fused_layer_ctrl.sv
// fused_layer_ctrl: sequences one fused-layer tile.
//   1. Copy the weights of NUM_LAYERS layers from global BRAM into fused BRAM (packed from 0).
//   2. Copy one IFM tile from global BRAM to fused BRAM, directly after the weights.
//   3. Pulse pe_start and wait for pe_done.
//   4. Copy the OFM tile from fused BRAM back to global BRAM.
//   5. Pulse done for one cycle and return to idle.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start / ready / done         tile handshake
//   cfg_*                        tile configuration, latched when start is accepted
//   *_global, *_fused            BRAM read/write address and enable pairs
//   control_load                 data-mux select (0 none, 1 ifm, 2 weight, 3 store)
//   pe_start / pe_done           PE array handshake
// Every BRAM read is matched by a write RD_LAT cycles later through a valid/address shift pipe.
module fused_layer_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         ready,
  output logic                         done,
  input  logic [NUM_LAYERS*ADDR_W-1:0] cfg_base_weight,
  input  logic [NUM_LAYERS*ADDR_W-1:0] cfg_size_weight,
  input  logic [ADDR_W-1:0]            cfg_base_ifm,
  input  logic [ADDR_W-1:0]            cfg_size_ifm,
  input  logic [ADDR_W-1:0]            cfg_base_ofm_fused,
  input  logic [ADDR_W-1:0]            cfg_base_ofm_global,
  input  logic [ADDR_W-1:0]            cfg_size_ofm,
  output logic [ADDR_W-1:0]            rd_addr_global,
  output logic [ADDR_W-1:0]            wr_addr_global,
  output logic                         rd_en_global,
  output logic                         we_global,
  output logic [ADDR_W-1:0]            rd_addr_fused,
  output logic [ADDR_W-1:0]            wr_addr_fused,
  output logic                         rd_en_fused,
  output logic                         we_fused,
  output logic [1:0]                   control_load,
  output logic                         pe_start,
  input  logic                         pe_done
);

  localparam int unsigned LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned CFG_W = NUM_LAYERS * ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_WEIGHT, S_LOAD_IFM, S_COMPUTE, S_STORE, S_DONE
  } state_t;

  state_t            state, ns;
  logic [CFG_W-1:0]  lat_base_w, lat_size_w, w_base_eff, w_size_eff;
  logic [ADDR_W-1:0] lat_base_ifm, lat_size_ifm, lat_ofm_fused, lat_ofm_global, lat_size_ofm;
  // Copy cursor: next read source, its destination, reads still to issue, current layer.
  logic [ADDR_W-1:0] src_ptr, dst_ptr, rd_left;
  logic [LW-1:0]     layer;
  logic [ADDR_W-1:0] cur_src, cur_dst, cur_left, nx_src, nx_dst, nx_left;
  logic [LW-1:0]     cur_layer, nx_layer;
  logic [LW:0]       hit, nx_hit;
  logic              copy_idle, issue;
  logic [RD_LAT-1:0] pv;
  logic [ADDR_W-1:0] pa [RD_LAT];

  // Lowest layer index >= from with a non-zero size; MSB flags a hit.
  function automatic logic [LW:0] find_layer(input int from, input logic [CFG_W-1:0] sizes);
    logic [LW:0] r;
    r = '0;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--)
      if (i >= from && sizes[i*ADDR_W +: ADDR_W] != '0) r = {1'b1, LW'(i)};
    return r;
  endfunction

  // Next-state and copy-cursor logic.
  always_comb begin
    // The first weight read is issued on the accepting edge, before the latch is loaded.
    w_base_eff = (state == S_IDLE) ? cfg_base_weight : lat_base_w;
    w_size_eff = (state == S_IDLE) ? cfg_size_weight : lat_size_w;
    copy_idle  = (rd_left == '0) && (pv == '0);

    ns = state;
    unique case (state)
      S_IDLE:        if (start) ns = S_LOAD_WEIGHT;
      S_LOAD_WEIGHT: if (copy_idle) ns = S_LOAD_IFM;
      S_LOAD_IFM:    if (copy_idle) ns = S_COMPUTE;
      S_COMPUTE:     if (!pe_start && pe_done) ns = S_STORE;  // pe_done ignored in the pe_start cycle
      S_STORE:       if (copy_idle) ns = S_DONE;
      S_DONE:        ns = S_IDLE;
      default:       ns = S_IDLE;
    endcase

    // On entry to a copy state the cursor restarts from that copy's first word.
    cur_src   = src_ptr;
    cur_dst   = dst_ptr;
    cur_left  = rd_left;
    cur_layer = layer;
    hit       = '0;
    if (ns != state) begin
      case (ns)
        S_LOAD_WEIGHT: begin
          hit       = find_layer(0, w_size_eff);
          cur_layer = hit[LW-1:0];
          cur_dst   = '0;
          cur_src   = hit[LW] ? w_base_eff[int'(hit[LW-1:0])*ADDR_W +: ADDR_W] : '0;
          cur_left  = hit[LW] ? w_size_eff[int'(hit[LW-1:0])*ADDR_W +: ADDR_W] : '0;
        end
        S_LOAD_IFM: begin
          cur_src  = lat_base_ifm;
          cur_left = lat_size_ifm;   // destination continues after the packed weights
        end
        S_STORE: begin
          cur_src  = lat_ofm_fused;
          cur_dst  = lat_ofm_global;
          cur_left = lat_size_ofm;
        end
        default: ;
      endcase
    end

    issue    = (ns inside {S_LOAD_WEIGHT, S_LOAD_IFM, S_STORE}) && (cur_left != '0);
    nx_src   = cur_src;
    nx_dst   = cur_dst;
    nx_left  = cur_left;
    nx_layer = cur_layer;
    nx_hit   = '0;
    if (issue) begin
      nx_src  = cur_src + ADDR_W'(1);
      nx_dst  = cur_dst + ADDR_W'(1);
      nx_left = cur_left - ADDR_W'(1);
      // Last word of a layer: jump straight to the next non-empty layer, no idle cycle.
      if (ns == S_LOAD_WEIGHT && cur_left == ADDR_W'(1)) begin
        nx_hit = find_layer(int'(cur_layer) + 1, w_size_eff);
        if (nx_hit[LW]) begin
          nx_layer = nx_hit[LW-1:0];
          nx_src   = w_base_eff[int'(nx_hit[LW-1:0])*ADDR_W +: ADDR_W];
          nx_left  = w_size_eff[int'(nx_hit[LW-1:0])*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // State, cursor, write pipe and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      lat_base_w     <= '0;
      lat_size_w     <= '0;
      lat_base_ifm   <= '0;
      lat_size_ifm   <= '0;
      lat_ofm_fused  <= '0;
      lat_ofm_global <= '0;
      lat_size_ofm   <= '0;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      rd_left        <= '0;
      layer          <= '0;
      pv             <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pa[i] <= '0;
      rd_addr_global <= '0;
      wr_addr_global <= '0;
      rd_en_global   <= 1'b0;
      we_global      <= 1'b0;
      rd_addr_fused  <= '0;
      wr_addr_fused  <= '0;
      rd_en_fused    <= 1'b0;
      we_fused       <= 1'b0;
      control_load   <= 2'd0;
      pe_start       <= 1'b0;
      ready          <= 1'b1;
      done           <= 1'b0;
    end else begin
      state <= ns;
      if (state == S_IDLE && start) begin
        lat_base_w     <= cfg_base_weight;
        lat_size_w     <= cfg_size_weight;
        lat_base_ifm   <= cfg_base_ifm;
        lat_size_ifm   <= cfg_size_ifm;
        lat_ofm_fused  <= cfg_base_ofm_fused;
        lat_ofm_global <= cfg_base_ofm_global;
        lat_size_ofm   <= cfg_size_ofm;
      end
      src_ptr <= nx_src;
      dst_ptr <= nx_dst;
      rd_left <= nx_left;
      layer   <= nx_layer;

      pv[0] <= issue;
      pa[0] <= cur_dst;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end

      rd_en_global <= issue && (ns != S_STORE);
      rd_en_fused  <= issue && (ns == S_STORE);
      if (issue) begin
        if (ns == S_STORE) rd_addr_fused  <= cur_src;
        else               rd_addr_global <= cur_src;
      end

      // A copy never leaves its state before the pipe drains, so state picks the write side.
      we_global <= pv[RD_LAT-1] && (state == S_STORE);
      we_fused  <= pv[RD_LAT-1] && (state != S_STORE);
      if (pv[RD_LAT-1]) begin
        if (state == S_STORE) wr_addr_global <= pa[RD_LAT-1];
        else                  wr_addr_fused  <= pa[RD_LAT-1];
      end

      case (ns)
        S_LOAD_IFM:    control_load <= 2'd1;
        S_LOAD_WEIGHT: control_load <= 2'd2;
        S_STORE:       control_load <= 2'd3;
        default:       control_load <= 2'd0;
      endcase
      ready    <= (ns == S_IDLE);
      done     <= (ns == S_DONE);
      pe_start <= (ns == S_COMPUTE) && (state != S_COMPUTE);
    end
  end

endmodule

// File: tb/tb_fused_layer_ctrl.sv
// Directed bench: instance a (2 layers, RD_LAT=1) runs full tiles, zero sizes,
// handshake corners and a mid-copy reset; instance b (1 layer, RD_LAT=3) checks latency.
module tb_fused_layer_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a
  logic        start, ready, done, pe_start, pe_done;
  logic [63:0] cfg_base_weight, cfg_size_weight;
  logic [31:0] cfg_base_ifm, cfg_size_ifm, cfg_base_ofm_fused, cfg_base_ofm_global, cfg_size_ofm;
  logic [31:0] rd_addr_global, wr_addr_global, rd_addr_fused, wr_addr_fused;
  logic        rd_en_global, we_global, rd_en_fused, we_fused;
  logic [1:0]  control_load;

  fused_layer_ctrl #(.ADDR_W(32), .NUM_LAYERS(2), .RD_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .done(done),
    .cfg_base_weight(cfg_base_weight), .cfg_size_weight(cfg_size_weight),
    .cfg_base_ifm(cfg_base_ifm), .cfg_size_ifm(cfg_size_ifm),
    .cfg_base_ofm_fused(cfg_base_ofm_fused), .cfg_base_ofm_global(cfg_base_ofm_global),
    .cfg_size_ofm(cfg_size_ofm),
    .rd_addr_global(rd_addr_global), .wr_addr_global(wr_addr_global),
    .rd_en_global(rd_en_global), .we_global(we_global),
    .rd_addr_fused(rd_addr_fused), .wr_addr_fused(wr_addr_fused),
    .rd_en_fused(rd_en_fused), .we_fused(we_fused),
    .control_load(control_load), .pe_start(pe_start), .pe_done(pe_done));

  // Instance b
  logic        start_b, ready_b, done_b, pe_start_b, pe_done_b;
  logic [31:0] cfg_base_weight_b, cfg_size_weight_b;
  logic [31:0] rd_addr_global_b, wr_addr_global_b, rd_addr_fused_b, wr_addr_fused_b;
  logic        rd_en_global_b, we_global_b, rd_en_fused_b, we_fused_b;
  logic [1:0]  control_load_b;

  fused_layer_ctrl #(.ADDR_W(32), .NUM_LAYERS(1), .RD_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .ready(ready_b), .done(done_b),
    .cfg_base_weight(cfg_base_weight_b), .cfg_size_weight(cfg_size_weight_b),
    .cfg_base_ifm(32'h0), .cfg_size_ifm(32'h0),
    .cfg_base_ofm_fused(32'h0), .cfg_base_ofm_global(32'h0), .cfg_size_ofm(32'h0),
    .rd_addr_global(rd_addr_global_b), .wr_addr_global(wr_addr_global_b),
    .rd_en_global(rd_en_global_b), .we_global(we_global_b),
    .rd_addr_fused(rd_addr_fused_b), .wr_addr_fused(wr_addr_fused_b),
    .rd_en_fused(rd_en_fused_b), .we_fused(we_fused_b),
    .control_load(control_load_b), .pe_start(pe_start_b), .pe_done(pe_done_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {rd_en_g, rd_en_f, we_g, we_f, control_load, ready, pe_start, done} of instance a
  function automatic logic [63:0] ctl_a();
    return 64'({rd_en_global, rd_en_fused, we_global, we_fused, control_load, ready, pe_start, done});
  endfunction

  // Checks one copy on instance a (RD_LAT=1): reads from two source segments, writes to d+k.
  task automatic copy_a(input string tag, input int n0, input logic [31:0] s0, input int n1,
                        input logic [31:0] s1, input logic [31:0] d, input bit to_g,
                        input logic [1:0] cl);
    int n;
    logic er, ew;
    logic [31:0] ra;
    n = n0 + n1;
    for (int k = 0; k <= n; k++) begin
      er = (k < n);
      ew = (k >= 1);
      ra = (k < n0) ? s0 + 32'(k) : s1 + 32'(k - n0);
      chk({tag, "_ctl"}, ctl_a(),
          64'({er & ~to_g, er & to_g, ew & to_g, ew & ~to_g, cl, 3'b000}));
      if (er) chk({tag, "_rd_addr"}, 64'(to_g ? rd_addr_fused : rd_addr_global), 64'(ra));
      if (ew) chk({tag, "_wr_addr"}, 64'(to_g ? wr_addr_global : wr_addr_fused), 64'(d + 32'(k - 1)));
      step();
    end
  endtask

  // Full tile on instance a, starting and ending in IDLE.
  task automatic run_tile(input string tag, input int n0, input logic [31:0] s0, input int n1,
                          input logic [31:0] s1, input int ni, input logic [31:0] si,
                          input int no, input logic [31:0] sf, input logic [31:0] sg,
                          input int pe_wait, input bit early, input bit disturb);
    cfg_base_weight     = {s1, s0};
    cfg_size_weight     = {32'(n1), 32'(n0)};
    cfg_base_ifm        = si;
    cfg_size_ifm        = 32'(ni);
    cfg_base_ofm_fused  = sf;
    cfg_base_ofm_global = sg;
    cfg_size_ofm        = 32'(no);
    start = 1'b1;
    step();
    start = 1'b0;
    copy_a({tag, "_lw"}, n0, s0, n1, s1, 32'h0, 1'b0, 2'd2);
    copy_a({tag, "_li"}, ni, si, 0, 32'h0, 32'(n0 + n1), 1'b0, 2'd1);
    for (int c = 0; c <= pe_wait; c++) begin
      chk({tag, "_compute"}, ctl_a(), 64'({4'b0000, 2'd0, 1'b0, (c == 0), 1'b0}));
      if (disturb && c == 1) begin
        start               = 1'b1;
        cfg_base_ofm_fused  = 32'hdead;
        cfg_base_ofm_global = 32'hbeef;
        cfg_size_ofm        = 32'd9;
        cfg_base_weight     = '1;
      end
      if (disturb && c == 2) start = 1'b0;
      if (c == (early ? 0 : pe_wait)) pe_done = 1'b1;
      step();
    end
    pe_done = 1'b0;
    copy_a({tag, "_st"}, no, sf, 0, 32'h0, sg, 1'b1, 2'd3);
    chk({tag, "_done"}, ctl_a(), 64'({4'b0000, 2'd0, 3'b001}));
    step();
    chk({tag, "_idle"}, ctl_a(), 64'({4'b0000, 2'd0, 3'b100}));
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; pe_done = 1'b0; start_b = 1'b0; pe_done_b = 1'b0;
    cfg_base_weight = '0; cfg_size_weight = '0; cfg_base_ifm = '0; cfg_size_ifm = '0;
    cfg_base_ofm_fused = '0; cfg_base_ofm_global = '0; cfg_size_ofm = '0;
    cfg_base_weight_b = '0; cfg_size_weight_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", ctl_a(), 64'({4'b0000, 2'd0, 3'b100}));
    chk("reset_addr", 64'({rd_addr_global, wr_addr_fused}), 64'h0);
    chk("reset_b_ctl", 64'({rd_en_global_b, we_fused_b, ready_b, control_load_b}), 64'b00100);
    reset_n = 1'b1;
    step();

    // Weights 0x100/4 and 0x200/3, IFM 0x40/2, OFM 0x20 -> 0x300, 2 words; start and cfg churn in COMPUTE.
    run_tile("t1", 4, 32'h100, 3, 32'h200, 2, 32'h40, 2, 32'h20, 32'h300, 5, 1'b0, 1'b1);
    step();
    chk("t1_start_ignored", ctl_a(), 64'({4'b0000, 2'd0, 3'b100}));

    // Layer 1 and IFM empty; pe_done already high in the pe_start cycle.
    run_tile("t4a", 3, 32'h500, 0, 32'h600, 0, 32'h40, 1, 32'h10, 32'h600, 1, 1'b1, 1'b0);
    step();
    // Layer 0 empty: layer 1 packs at 0 and the IFM follows at 2.
    run_tile("t4b", 0, 32'h900, 2, 32'h700, 1, 32'h44, 0, 32'h10, 32'h600, 2, 1'b0, 1'b0);
    step();

    // Reset in the third cycle of LOAD_WEIGHT, then re-run the first tile.
    cfg_base_weight = {32'h200, 32'h100};
    cfg_size_weight = {32'd3, 32'd4};
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t6_pre_rd", 64'(rd_addr_global), 64'h102);
    reset_n = 1'b0;
    #1;
    chk("t6_abort", ctl_a(), 64'({4'b0000, 2'd0, 3'b100}));
    step();
    reset_n = 1'b1;
    step();
    chk("t6_quiet", ctl_a(), 64'({4'b0000, 2'd0, 3'b100}));
    run_tile("t6", 4, 32'h100, 3, 32'h200, 2, 32'h40, 2, 32'h20, 32'h300, 5, 1'b0, 1'b0);

    // RD_LAT=3, one 5-word layer at 0x1000; remaining copies empty.
    cfg_base_weight_b = 32'h1000;
    cfg_size_weight_b = 32'd5;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("t3_ctl", 64'({rd_en_global_b, rd_en_fused_b, we_global_b, we_fused_b, control_load_b}),
          64'({(k < 5), 1'b0, 1'b0, (k >= 3), 2'd2}));
      if (k < 5)  chk("t3_rd_addr", 64'(rd_addr_global_b), 64'(32'h1000 + 32'(k)));
      if (k >= 3) chk("t3_wr_addr", 64'(wr_addr_fused_b), 64'(k - 3));
      step();
    end
    chk("t3_ifm", 64'({rd_en_global_b, we_fused_b, control_load_b, pe_start_b}), 64'b00010);
    pe_done_b = 1'b1;
    step();
    chk("t3_pe_start", 64'({control_load_b, pe_start_b}), 64'b001);
    step();
    chk("t3_compute", 64'({control_load_b, pe_start_b}), 64'b000);
    step();
    pe_done_b = 1'b0;
    chk("t3_store", 64'({rd_en_fused_b, we_global_b, control_load_b, done_b}), 64'b00110);
    step();
    chk("t3_done", 64'({done_b, ready_b}), 64'b10);
    step();
    chk("t3_idle", 64'({done_b, ready_b}), 64'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
